mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning the RAM word-address width.
REQ-002 SHALL have parameter BURST_MAX, default 4, meaning the maximum consecutive m0 grants while m1 waits (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports m0_req/m1_req, input, 1, access request from the CPU memory stage (m0) and the loader/debug master (m1).
REQ-006 SHALL have ports mX_we, input, 1, write (1) or read (0).
REQ-007 SHALL have ports mX_addr, input, ADDR_W, word address.
REQ-008 SHALL have ports mX_wdata, input, 32, store data, byte lanes already positioned.
REQ-009 SHALL have ports mX_wmask, input, 4, byte write enables; ignored when mX_we=0.
REQ-010 SHALL have ports mX_gnt, output, 1, request accepted this cycle.
REQ-011 SHALL have ports mX_rvalid, output, 1, read data valid for master X.
REQ-012 SHALL have ports mX_rdata, output, 32, read data.
REQ-013 SHALL have ports ram_en, ram_we[3:0], ram_addr[ADDR_W-1:0], ram_wdata[31:0], output, driving one single-port synchronous RAM.
REQ-014 SHALL have port ram_rdata, input, 32, RAM read data, valid one cycle after ram_en with ram_we=0.

Function
REQ-015 Grant SHALL be combinational from requests and registered state; at most one of m0_gnt/m1_gnt is high per cycle.
REQ-016 Only m0 requesting -> m0_gnt=1; only m1 requesting -> m1_gnt=1; neither -> ram_en=0, ram_we=0.
REQ-017 Both requesting -> m0 SHALL win, unless starve_cnt == BURST_MAX, in which case m1 SHALL win.
REQ-018 starve_cnt (4 bits) SHALL increment when m0 is granted while m1_req=1.
REQ-019 starve_cnt SHALL clear when m1 is granted or m1_req=0, and SHALL saturate at BURST_MAX.
REQ-020 In the granted cycle, ram_en=1 and ram_addr/ram_wdata SHALL equal the winner's inputs.
REQ-021 In the granted cycle, ram_we SHALL equal the winner's wmask when we=1, else 4'b0000.
REQ-022 Requesters SHALL hold req and all request fields stable until gnt; a req drop before gnt SHALL be a legal cancel with no side effect.
REQ-023 Granted read: mX_rvalid=1 for exactly one cycle, the cycle after gnt, with mX_rdata=ram_rdata.
REQ-024 Read owner tag SHALL be registered at grant; the other master's rvalid SHALL stay 0.
REQ-025 Granted write: no rvalid; the write SHALL complete at the grant edge.
REQ-026 Back-to-back grants SHALL be accepted every cycle (throughput 1 access/cycle); a read followed by a write to the same address SHALL return pre-write data.
REQ-027 mX_rdata SHALL be driven from ram_rdata for both masters; it is meaningful only when mX_rvalid=1.

Reset
REQ-028 RESET high SHALL immediately force starve_cnt=0, rvalid pipeline regs=0 and owner tag=m0, so mX_rvalid=0 asynchronously.
REQ-029 While RESET is high, mX_gnt=0, ram_en=0 and ram_we=0 regardless of requests.
REQ-030 A read granted in the cycle RESET asserts SHALL never produce rvalid.
REQ-031 Release SHALL resume normal arbitration on the first clk edge after RESET falls.

Structure
REQ-032 Master ID encoding (M0=0, M1=1) and the default BURST_MAX SHALL live in a shared package of core constants.
REQ-033 No sub-module SHALL be instantiated; the starvation counter is inline logic; the RAM stays outside the block.

Verification
REQ-034 m0 read addr 0x010, RAM[0x010]=0xDEADBEEF, m1 idle -> m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1_rvalid=0.
REQ-035 m0 and m1 both hold req continuously, BURST_MAX=4 -> grant sequence m0,m0,m0,m0,m1, repeating.
REQ-036 m1 write addr 0x020, wdata 0x11223344, wmask 4'b0100, RAM[0x020]=0 -> m1 read of 0x020 returns 0x00220000.
REQ-037 m0 write addr 0x030 = 0xA5A5A5A5 granted cycle N, m1 read addr 0x030 granted N+1 -> m1_rvalid at N+2 with 0xA5A5A5A5.
REQ-038 RESET pulsed in the cycle after an m1 read grant -> m1_rvalid stays 0, starve_cnt=0; first post-reset contention grants m0.
REQ-039 m1 asserts req one cycle then drops while m0 holds priority -> no m1_gnt, no RAM write, starve_cnt=0 after drop.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: core constants shared by the memory arbiter and its users.
//   mst_id_e      - master ID encoding (M0 = CPU memory stage, M1 = loader/debug)
//   BURST_MAX_DEF - default number of consecutive m0 grants allowed while m1 waits
//   STARVE_W      - width of the starvation counter
package mem_arbiter_pkg;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_id_e;

    localparam int BURST_MAX_DEF = 4;
    localparam int STARVE_W      = 4;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of one single-port synchronous RAM.
// m0 has fixed priority, bounded by a starvation counter so that m1 wins after
// BURST_MAX consecutive contended m0 grants. Grants are combinational, giving
// one access per cycle; read data returns one cycle after the grant.
//
// Ports
//   clk, RESET                   clock, asynchronous active-high reset
//   mX_req/we/addr/wdata/wmask   request from master X (held until mX_gnt)
//   mX_gnt                       request accepted this cycle
//   mX_rvalid, mX_rdata          read response, one cycle after a read grant
//   ram_en/we/addr/wdata         RAM command (driven during the grant cycle)
//   ram_rdata                    RAM read data, valid one cycle after a read
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              RESET,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [STARVE_W-1:0] BURST_LIM = STARVE_W'(BURST_MAX);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;
    mst_id_e             winner;
    logic                win_we;
    logic [3:0]          win_mask;
    logic                rd_vld;
    mst_id_e             rd_owner;

    assign starve_hit = (starve_cnt == BURST_LIM);

    // Grant: m0 by default, m1 once m0 has used up its burst allowance.
    // Reset masks both so nothing reaches the RAM while RESET is high.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!RESET) begin
            if (m0_req && !(m1_req && starve_hit))
                m0_gnt = 1'b1;
            else if (m1_req)
                m1_gnt = 1'b1;
        end
    end

    assign winner    = m1_gnt ? MST_M1 : MST_M0;
    assign win_we    = (winner == MST_M1) ? m1_we    : m0_we;
    assign win_mask  = (winner == MST_M1) ? m1_wmask : m0_wmask;
    assign ram_en    = m0_gnt | m1_gnt;
    assign ram_addr  = (winner == MST_M1) ? m1_addr  : m0_addr;
    assign ram_wdata = (winner == MST_M1) ? m1_wdata : m0_wdata;
    assign ram_we    = (ram_en && win_we) ? win_mask : 4'b0000;

    // Counter advances only on contended m0 grants; any cycle where m1 is
    // served or stops asking resets the allowance.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            starve_cnt <= '0;
            rd_vld     <= 1'b0;
            rd_owner   <= MST_M0;
        end else begin
            if (m0_gnt && m1_req)
                starve_cnt <= starve_hit ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;

            rd_vld <= ram_en && !win_we;
            if (ram_en)
                rd_owner <= winner;
        end
    end

    assign m0_rvalid = rd_vld && (rd_owner == MST_M0);
    assign m1_rvalid = rd_vld && (rd_owner == MST_M1);
    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter with a behavioural RAM.
// Read responses are checked by a scoreboard monitor fed from a queue of
// hand-computed expected (master, data) pairs.
module tb_mem_arbiter;

    localparam int AW = 14;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
    } mreq_t;

    typedef struct {
        logic        mst;
        logic [31:0] data;
    } exp_t;

    logic          clk, RESET;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_wmask, m1_wmask;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;
    logic [31:0]   mem [0:(1<<AW)-1];

    exp_t exp_q[$];
    int   n_cmp, n_err;

    mem_arbiter #(.ADDR_W(AW), .BURST_MAX(4)) dut (
        .clk(clk), .RESET(RESET),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM, read-first; pl_* backdoor for preloading.
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (ram_en) begin
            if (ram_we == 4'b0000)
                ram_rdata <= mem[ram_addr];
            for (int i = 0; i < 4; i++)
                if (ram_we[i])
                    mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
    end

    function automatic mreq_t idle();
        mreq_t r;
        r = '0;
        return r;
    endfunction

    function automatic mreq_t rd(input logic [AW-1:0] a);
        mreq_t r;
        r = '0;
        r.req = 1'b1;
        r.addr = a;
        return r;
    endfunction

    function automatic mreq_t wr(input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [3:0] m);
        mreq_t r;
        r.req = 1'b1;
        r.we = 1'b1;
        r.addr = a;
        r.wdata = d;
        r.wmask = m;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic drive(input mreq_t r0, input mreq_t r1);
        m0_req = r0.req; m0_we = r0.we; m0_addr = r0.addr;
        m0_wdata = r0.wdata; m0_wmask = r0.wmask;
        m1_req = r1.req; m1_we = r1.we; m1_addr = r1.addr;
        m1_wdata = r1.wdata; m1_wmask = r1.wmask;
    endtask

    // One cycle: drive requests, check grant at negedge, advance past posedge.
    task automatic step(input mreq_t r0, input mreq_t r1, input logic eg0,
                        input logic eg1, input string nm);
        drive(r0, r1);
        @(negedge clk);
        chk({nm, "_gnt"}, {30'b0, m0_gnt, m1_gnt}, {30'b0, eg0, eg1});
        chk({nm, "_ram_en"}, {31'b0, ram_en}, {31'b0, eg0 | eg1});
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic expect_rd(input logic mst, input logic [31:0] d);
        exp_t e;
        e.mst = mst;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_rvalid && m1_rvalid) begin
                n_cmp++;
                n_err++;
                $display("FAIL rvalid_onehot: both rvalid high, required at most one");
            end else if (m0_rvalid || m1_rvalid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rvalid_unexpected: m1_rvalid=%0b data=%h, required no response",
                             m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid_owner", {31'b0, m1_rvalid}, {31'b0, e.mst});
                    chk("rdata", m1_rvalid ? m1_rdata : m0_rdata, e.data);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        RESET = 1'b1;
        drive(rd(14'h010), rd(14'h011));
        fork
            monitor();
            begin
                #1_000_000;
                $display("FAIL watchdog: time limit reached, required completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset: requests present but everything masked.
        @(negedge clk);
        chk("rst_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h0);
        chk("rst_ram_en", {31'b0, ram_en}, 32'h0);
        chk("rst_ram_we", {28'b0, ram_we}, 32'h0);
        chk("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
        @(posedge clk);
        #1;
        drive(idle(), idle());
        RESET = 1'b0;

        preload(14'h010, 32'hDEADBEEF);
        preload(14'h020, 32'h00000000);
        preload(14'h040, 32'h12345678);
        preload(14'h050, 32'h0BADF00D);
        preload(14'h060, 32'hCAFEF00D);

        // Single m0 read.
        expect_rd(1'b0, 32'hDEADBEEF);
        step(rd(14'h010), idle(), 1'b1, 1'b0, "m0_rd");
        step(idle(), idle(), 1'b0, 1'b0, "idle0");

        // m1 partial write then read back.
        step(idle(), wr(14'h020, 32'h11223344, 4'b0100), 1'b0, 1'b1, "m1_wr_mask");
        expect_rd(1'b1, 32'h00220000);
        step(idle(), rd(14'h020), 1'b0, 1'b1, "m1_rd_mask");

        // m0 write, m1 read same address on the very next cycle.
        step(wr(14'h030, 32'hA5A5A5A5, 4'b1111), idle(), 1'b1, 1'b0, "m0_wr_30");
        expect_rd(1'b1, 32'hA5A5A5A5);
        step(idle(), rd(14'h030), 1'b0, 1'b1, "m1_rd_30");

        // Read then write same address back to back: read sees old data.
        expect_rd(1'b0, 32'h12345678);
        step(rd(14'h040), idle(), 1'b1, 1'b0, "m0_rd_40");
        step(wr(14'h040, 32'hFFFFFFFF, 4'b1111), idle(), 1'b1, 1'b0, "m0_wr_40");
        expect_rd(1'b1, 32'hFFFFFFFF);
        step(idle(), rd(14'h040), 1'b0, 1'b1, "m1_rd_40");
        step(idle(), idle(), 1'b0, 1'b0, "idle1");

        // Continuous contention: m0 x4 then m1, repeating.
        for (int i = 0; i < 10; i++)
            step(wr(14'h100, 32'h0, 4'b0000), wr(14'h101, 32'h0, 4'b0000),
                 (i % 5) != 4, (i % 5) == 4, "contend");
        step(idle(), idle(), 1'b0, 1'b0, "idle2");

        // m1 cancels before being granted: no write, counter back to 0.
        step(wr(14'h051, 32'h55555555, 4'b1111), wr(14'h050, 32'hFFFFFFFF, 4'b1111),
             1'b1, 1'b0, "cancel_a");
        step(wr(14'h051, 32'h55555555, 4'b1111), idle(), 1'b1, 1'b0, "cancel_b");
        chk("cancel_starve", {28'b0, dut.starve_cnt}, 32'h0);
        expect_rd(1'b0, 32'h0BADF00D);
        step(rd(14'h050), idle(), 1'b1, 1'b0, "cancel_rd");
        step(idle(), idle(), 1'b0, 1'b0, "idle3");

        // Reset right after an m1 read grant kills the pending response.
        step(idle(), rd(14'h060), 1'b0, 1'b1, "m1_rd_pre_rst");
        RESET = 1'b1;
        #1;
        chk("rst_kill_rvalid", {31'b0, m1_rvalid}, 32'h0);
        step(rd(14'h061), rd(14'h062), 1'b0, 1'b0, "in_rst");
        chk("rst_starve", {28'b0, dut.starve_cnt}, 32'h0);
        RESET = 1'b0;
        step(wr(14'h070, 32'h1, 4'b0001), wr(14'h071, 32'h2, 4'b0001),
             1'b1, 1'b0, "post_rst_contend");

        drive(idle(), idle());
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
